// File: rtl/rr_grant_arbiter.sv
// Round-robin packet arbiter: grant is held from first beat to the accepted last beat.
// Define ARB_WATCHDOG_EN to build the stall watchdog that force-releases a stuck grant.

// Bit-position search: MODE=0 returns the trailing-zero count, MODE=1 the leading-zero count.
module lazy_counter #(
    parameter int W    = 4,
    parameter int MODE = 0,
    parameter int CW   = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] cnt,
    output logic          zero
);
    always_comb begin
        cnt  = '0;
        zero = (vec == '0);
        if (MODE == 0) begin
            for (int i = W-1; i >= 0; i--)
                if (vec[i]) cnt = CW'(i);
        end else begin
            for (int i = W-1; i >= 0; i--)
                if (vec[W-1-i]) cnt = CW'(i);
        end
    end
endmodule

module rr_grant_arbiter #(
    parameter int N       = 4,
    parameter int LOGN    = $clog2(N),
    parameter int TIMEOUT = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic            ack_i,
    input  logic            last_i,
    output logic [N-1:0]    gnt_o,
    output logic [LOGN-1:0] gnt_idx_o,
    output logic            gnt_valid_o,
    output logic            abort_o,
    output logic            timeout_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [LOGN-1:0] ptr;
    logic [LOGN-1:0] mask_ptr;
    logic [N-1:0]    mask;
    logic [N-1:0]    req_masked;
    logic [LOGN-1:0] idx_masked;
    logic [LOGN-1:0] idx_raw;
    logic            zero_masked;
    logic            zero_raw;
    logic [LOGN-1:0] win_idx;
    logic            win_valid;
    logic            rel_norm;
    logic            rel_abort;
    logic            rel_tmo;
    logic            release_ev;

    // On a release the pointer update and the new search happen in one cycle,
    // so the mask is taken from the outgoing grant rather than from ptr.
    assign mask_ptr = (state == BUSY) ? gnt_idx_o : ptr;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++)
            mask[i] = (i > int'(mask_ptr));
    end

    assign req_masked = req_i & mask;

    lazy_counter #(.W(N), .MODE(0), .CW(LOGN)) u_tzc_masked (
        .vec  (req_masked),
        .cnt  (idx_masked),
        .zero (zero_masked)
    );

    lazy_counter #(.W(N), .MODE(0), .CW(LOGN)) u_tzc_raw (
        .vec  (req_i),
        .cnt  (idx_raw),
        .zero (zero_raw)
    );

    assign win_idx   = zero_masked ? idx_raw : idx_masked;
    assign win_valid = !zero_raw;

    assign rel_norm   = ack_i & last_i;
    assign rel_abort  = !req_i[gnt_idx_o];
    assign release_ev = (state == BUSY) && (rel_norm || rel_abort || rel_tmo);

`ifdef ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT+1);
    logic [WDW-1:0] wd_cnt;

    // Fires on the cycle whose increment would make the count reach TIMEOUT.
    assign rel_tmo = (state == BUSY) && (wd_cnt == WDW'(TIMEOUT-1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= (state == BUSY) && !rel_norm && !rel_abort && rel_tmo;
            if (state != BUSY || ack_i || release_ev)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign rel_tmo   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ptr         <= LOGN'(N-1);
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            abort_o     <= 1'b0;
        end else begin
            abort_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt_o       <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                        gnt_idx_o   <= win_idx;
                        gnt_valid_o <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_ev) begin
                        ptr     <= gnt_idx_o;
                        abort_o <= !rel_norm && rel_abort;
                        if (win_valid) begin
                            gnt_o     <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                            gnt_idx_o <= win_idx;
                        end else begin
                            gnt_o       <= '0;
                            gnt_idx_o   <= '0;
                            gnt_valid_o <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: per-cycle expected grant state is queued
// as stimulus is driven and compared when the clocked outputs settle.
module tb_rr_grant_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         ack = 1'b0;
    logic         last = 1'b0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_valid;
    logic         abort;
    logic         tmo;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
        logic       abort;
        logic       tmo;
    } exp_t;

    exp_t sb[$];

    rr_grant_arbiter #(.N(N), .TIMEOUT(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .ack_i       (ack),
        .last_i      (last),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid),
        .abort_o     (abort),
        .timeout_o   (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        logic [N-1:0] onehot;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        onehot = e.valid ? (N'(1) << e.idx) : '0;
        chk("gnt_valid", 32'(gnt_valid), 32'(e.valid));
        chk("gnt_idx",   32'(gnt_idx),   32'(e.idx));
        chk("gnt",       32'(gnt),       32'(onehot));
        chk("abort",     32'(abort),     32'(e.abort));
        chk("timeout",   32'(tmo),       32'(e.tmo));
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic a, input logic l,
                        input logic ev, input logic [1:0] ei, input logic ea, input logic et);
        exp_t e;
        rst  = r;
        req  = rq;
        ack  = a;
        last = l;
        e.valid = ev; e.idx = ei; e.abort = ea; e.tmo = et;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare_out();
    endtask

    initial begin
        // reset state
        step(1, 4'b0000, 0, 0, 0, 2'd0, 0, 0);
        step(1, 4'b1111, 1, 1, 0, 2'd0, 0, 0);

        // full rotation 0,1,2,3,0 without gaps
        step(0, 4'b1111, 0, 0, 1, 2'd0, 0, 0);
        step(0, 4'b1111, 1, 0, 1, 2'd0, 0, 0);
        step(0, 4'b1111, 1, 1, 1, 2'd1, 0, 0);
        step(0, 4'b1111, 1, 1, 1, 2'd2, 0, 0);
        step(0, 4'b1111, 1, 1, 1, 2'd3, 0, 0);
        step(0, 4'b1111, 1, 1, 1, 2'd0, 0, 0);
        step(0, 4'b0000, 1, 1, 0, 2'd0, 0, 0);

        // sole requester re-granted back to back
        step(0, 4'b0100, 0, 0, 1, 2'd2, 0, 0);
        step(0, 4'b0100, 1, 1, 1, 2'd2, 0, 0);
        step(0, 4'b0100, 1, 1, 1, 2'd2, 0, 0);
        step(0, 4'b0000, 1, 1, 0, 2'd0, 0, 0);

        // skip over non-requesters, then wrap
        step(0, 4'b0010, 0, 0, 1, 2'd1, 0, 0);
        step(0, 4'b1011, 1, 1, 1, 2'd3, 0, 0);
        step(0, 4'b0001, 1, 1, 1, 2'd0, 0, 0);

        // abort: granted stream drops its request early
        step(0, 4'b0101, 1, 1, 1, 2'd2, 0, 0);
        step(0, 4'b1001, 0, 0, 1, 2'd3, 1, 0);
        step(0, 4'b1001, 0, 0, 1, 2'd3, 0, 0);
        step(0, 4'b1111, 0, 0, 1, 2'd3, 0, 0);

        // same drop but with ack&last: normal release wins
        step(0, 4'b0101, 1, 1, 1, 2'd0, 0, 0);
        step(0, 4'b0101, 1, 1, 1, 2'd2, 0, 0);
        step(0, 4'b1001, 1, 1, 1, 2'd3, 0, 0);
        step(0, 4'b1001, 0, 0, 1, 2'd3, 0, 0);

        // reset mid-packet with a dropped request: no pulses
        step(1, 4'b0000, 0, 0, 0, 2'd0, 0, 0);
        step(0, 4'b0000, 1, 1, 0, 2'd0, 0, 0);
        step(0, 4'b1111, 0, 0, 1, 2'd0, 0, 0);

`ifdef ARB_WATCHDOG_EN
        for (int i = 0; i < 7; i++)
            step(0, 4'b0011, 0, 0, 1, 2'd0, 0, 0);
        step(0, 4'b0011, 0, 0, 1, 2'd1, 0, 1);
        step(0, 4'b0011, 0, 0, 1, 2'd1, 0, 0);
`else
        for (int i = 0; i < 100; i++)
            step(0, 4'b0011, 0, 0, 1, 2'd0, 0, 0);
`endif
        step(0, 4'b0000, 1, 1, 0, 2'd0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
